layer_featuremap_packer: RTL

Channel-serial to channel-parallel packer that produces the wide input stream consumed by a layer feature-map block. It accepts one 32-bit IEEE-754 value per handshake, channel 0 first, and assembles CHANNELS values into one DATA_OUT_WIDTH word per pixel. It emits that word with a one-cycle valid strobe, so each Conv2D3x3 lane receives its own channel slice. Frame sequencing, with raster pixel count IMG_SIZE×IMG_SIZE, is handled internally and reported with a done pulse.

---
 rtl/layer_featuremap_packer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/layer_featuremap_packer.sv
// Channel-serial to channel-parallel packer: CHANNELS beats of DATA_WIDTH form one pixel word.
// Optional macro FEATMAP_PACKER_COORD_EN adds row_out/col_out raster coordinates of each emitted pixel.
module layer_featuremap_packer #(
  parameter int DATA_WIDTH     = 32,
  parameter int CHANNELS       = 16,
  parameter int DATA_OUT_WIDTH = 512,
  parameter int IMG_SIZE       = 208
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      start,
  input  logic [DATA_WIDTH-1:0]     data_in,
  input  logic                      valid_in,
  output logic                      ready_in,
  output logic [DATA_OUT_WIDTH-1:0] data_out,
  output logic                      valid_out,
  output logic                      frame_done
`ifdef FEATMAP_PACKER_COORD_EN
  ,
  output logic [$clog2(IMG_SIZE)-1:0] row_out,
  output logic [$clog2(IMG_SIZE)-1:0] col_out
`endif
);

  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PIX_W = $clog2(IMG_SIZE * IMG_SIZE + 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(CHANNELS - 1);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(IMG_SIZE * IMG_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                    state;
  state_t                    next_state;
  logic [CH_W-1:0]           ch_cnt;
  logic [PIX_W-1:0]          pix_cnt;
  logic [DATA_OUT_WIDTH-1:0] asm_reg;
  logic [DATA_OUT_WIDTH-1:0] packed_word;
  logic                      accept;
  logic                      last_ch;
  logic                      last_pix;

  assign accept   = valid_in && ready_in;
  assign last_ch  = (ch_cnt == LAST_CH);
  assign last_pix = (pix_cnt == LAST_PIX);

  always_ff @(posedge Clk) begin
    if (!Rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    ready_in   = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = STREAM;
      end
      STREAM: begin
        ready_in = 1'b1;
        if (accept && last_ch && last_pix) next_state = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The top slice bypasses the assembly register so the word can emit on the last beat.
  always_comb begin
    packed_word = asm_reg;
    packed_word[DATA_OUT_WIDTH-1 -: DATA_WIDTH] = data_in;
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      ch_cnt    <= '0;
      pix_cnt   <= '0;
      asm_reg   <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (state == IDLE && start) begin
        ch_cnt  <= '0;
        pix_cnt <= '0;
      end else if (accept) begin
        if (last_ch) begin
          ch_cnt    <= '0;
          data_out  <= packed_word;
          valid_out <= 1'b1;
          pix_cnt   <= pix_cnt + 1'b1;
        end else begin
          asm_reg[ch_cnt*DATA_WIDTH +: DATA_WIDTH] <= data_in;
          ch_cnt <= ch_cnt + 1'b1;
        end
      end
    end
  end

`ifdef FEATMAP_PACKER_COORD_EN
  logic [$clog2(IMG_SIZE)-1:0] row_cnt;
  logic [$clog2(IMG_SIZE)-1:0] col_cnt;

  // row_cnt/col_cnt point at the pixel being assembled; the *_out copies follow data_out.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      row_cnt <= '0;
      col_cnt <= '0;
      row_out <= '0;
      col_out <= '0;
    end else if (state == IDLE && start) begin
      row_cnt <= '0;
      col_cnt <= '0;
    end else if (accept && last_ch) begin
      row_out <= row_cnt;
      col_out <= col_cnt;
      if (col_cnt == ($clog2(IMG_SIZE))'(IMG_SIZE - 1)) begin
        col_cnt <= '0;
        row_cnt <= row_cnt + 1'b1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end
`endif

endmodule
